// File: rtl/plic_lite_pkg.sv
// plic_lite shared definitions: register indices and FSM state encoding.
package plic_lite_pkg;

  localparam logic [2:0] PLIC_PENDING  = 3'd0;
  localparam logic [2:0] PLIC_ENABLE   = 3'd1;
  localparam logic [2:0] PLIC_CLAIM    = 3'd2;
  localparam logic [2:0] PLIC_COMPLETE = 3'd3;
  localparam logic [2:0] PLIC_TYPE     = 3'd4;

  typedef enum logic [1:0] {
    PLIC_IDLE   = 2'd0,
    PLIC_ASSERT = 2'd1,
    PLIC_INSVC  = 2'd2
  } plic_state_e;

endpackage

// File: rtl/plic_lite_src_sync.sv
// plic_src_sync: 2-flop synchronizer for one interrupt line plus rising-edge
// detect against the previous synchronized value.
module plic_src_sync (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise,
  output logic level
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Synchronizer chain and edge history.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      prev_q <= sync_q[1];
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~prev_q;

endmodule

// File: rtl/plic_lite.sv
// plic_lite: minimal wishbone-slave interrupt controller with a
// claim/complete handshake toward the core.
// Optional build macro PLIC_LEVEL_EN adds the TYPE register (level-mode sources).
//
//   state       | meaning
//   PLIC_IDLE   | nothing presented, o_irq low
//   PLIC_ASSERT | o_irq high, waiting for the core to take it
//   PLIC_INSVC  | core is servicing, o_irq low until COMPLETE is written
module plic_lite
  import plic_lite_pkg::*;
#(
  parameter int NUM_SRC  = 8,
  parameter int ADDR_LSB = 2
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic               i_wb_we,
  input  logic [31:0]        i_wb_adr,
  input  logic [31:0]        i_wb_dat,
  input  logic [3:0]         i_wb_sel,
  output logic [31:0]        o_wb_dat,
  output logic               o_wb_ack,
  input  logic [NUM_SRC-1:0] i_src,
  output logic               o_irq,
  input  logic               i_ack
);

  logic [NUM_SRC-1:0] src_rise;
  logic [NUM_SRC-1:0] src_level;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] type_mask;
  logic [NUM_SRC-1:0] hit;
  logic [NUM_SRC-1:0] claim_onehot;
  logic [4:0]         claim_id;
  logic [31:0]        rd_data;
  logic [2:0]         reg_idx;
  logic               ack_q;
  logic               bus_req;
  logic               bus_wr;
  logic               bus_rd;
  logic               wr_pending;
  logic               wr_enable;
  logic               wr_complete;
  logic               rd_claim;
  plic_state_e        state_q;
  plic_state_e        state_d;
  logic               unused_bits;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    plic_src_sync u_sync (
      .clk   (i_clk),
      .rstn  (i_rstn),
      .din   (i_src[g]),
      .rise  (src_rise[g]),
      .level (src_level[g])
    );
  end

  // Byte lanes, undecoded address bits and unused data bits are don't-care.
  assign unused_bits = ^{i_wb_sel, i_wb_adr, i_wb_dat};

  assign bus_req     = i_wb_cyc & i_wb_stb;
  assign reg_idx     = i_wb_adr[ADDR_LSB+2:ADDR_LSB];
  // Side effects happen on the ack cycle while the master still holds the strobe.
  assign bus_wr      = ack_q & bus_req & i_wb_we;
  assign bus_rd      = ack_q & bus_req & ~i_wb_we;
  assign wr_pending  = bus_wr && (reg_idx == PLIC_PENDING);
  assign wr_enable   = bus_wr && (reg_idx == PLIC_ENABLE);
  assign wr_complete = bus_wr && (reg_idx == PLIC_COMPLETE);
  assign rd_claim    = bus_rd && (reg_idx == PLIC_CLAIM);
  assign hit         = pending_q & enable_q;

  // Ack one cycle after the request, never two cycles in a row.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) ack_q <= 1'b0;
    else         ack_q <= bus_req & ~ack_q;
  end

  assign o_wb_ack = ack_q;

  // Lowest-index pending & enabled source wins the claim.
  always_comb begin
    claim_id     = 5'd0;
    claim_onehot = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (hit[i]) begin
        claim_id        = 5'(i + 1);
        claim_onehot    = '0;
        claim_onehot[i] = 1'b1;
      end
    end
  end

`ifdef PLIC_LEVEL_EN
  logic [NUM_SRC-1:0] type_q;

  // Per-source trigger mode: 1 = level, 0 = edge.
  always_ff @(posedge i_clk) begin
    if (!i_rstn)                                 type_q <= '0;
    else if (bus_wr && (reg_idx == PLIC_TYPE))   type_q <= i_wb_dat[NUM_SRC-1:0];
  end

  assign type_mask = type_q;
`else
  assign type_mask = '0;
`endif

  // Clears are applied first so a same-cycle set (edge or level) wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_pending) pending_d = pending_d & ~i_wb_dat[NUM_SRC-1:0];
    if (rd_claim)   pending_d = pending_d & ~claim_onehot;
    pending_d = pending_d | src_rise | (type_mask & src_level);
  end

  // Pending and enable registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      pending_q <= '0;
      enable_q  <= '0;
    end else begin
      pending_q <= pending_d;
      if (wr_enable) enable_q <= i_wb_dat[NUM_SRC-1:0];
    end
  end

  // Read mux; data is only driven while ack is high.
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      PLIC_PENDING: rd_data[NUM_SRC-1:0] = pending_q;
      PLIC_ENABLE:  rd_data[NUM_SRC-1:0] = enable_q;
      PLIC_CLAIM:   rd_data[4:0]         = claim_id;
`ifdef PLIC_LEVEL_EN
      PLIC_TYPE:    rd_data[NUM_SRC-1:0] = type_q;
`endif
      default:      rd_data              = '0;
    endcase
  end

  assign o_wb_dat = ack_q ? rd_data : 32'd0;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) state_q <= PLIC_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state and irq output.
  always_comb begin
    state_d = state_q;
    o_irq   = 1'b0;
    case (state_q)
      PLIC_IDLE: begin
        if (|hit) state_d = PLIC_ASSERT;
      end
      PLIC_ASSERT: begin
        o_irq = 1'b1;
        if (i_ack)     state_d = PLIC_INSVC;
        else if (!(|hit)) state_d = PLIC_IDLE;
      end
      PLIC_INSVC: begin
        if (wr_complete) state_d = PLIC_IDLE;
      end
      default: state_d = PLIC_IDLE;
    endcase
  end

endmodule

// File: tb/tb_plic_lite.sv
// tb_plic_lite: directed scenarios plus randomized bus/source traffic checked
// against a transaction-level model of the controller.
module tb_plic_lite;

  localparam int NUM_SRC = 8;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic        i_wb_we = 1'b0;
  logic [31:0] i_wb_adr = '0;
  logic [31:0] i_wb_dat = '0;
  logic [3:0]  i_wb_sel = '0;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack;
  logic [7:0]  i_src = '0;
  logic        o_irq;
  logic        i_ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_pend = '0;
  logic [7:0] m_en = '0;
  logic [7:0] m_type = '0;
  logic [7:0] m_level_hi = '0;
  bit         m_insvc = 1'b0;

  plic_lite #(.NUM_SRC(NUM_SRC), .ADDR_LSB(2)) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_wb_cyc (i_wb_cyc),
    .i_wb_stb (i_wb_stb),
    .i_wb_we  (i_wb_we),
    .i_wb_adr (i_wb_adr),
    .i_wb_dat (i_wb_dat),
    .i_wb_sel (i_wb_sel),
    .o_wb_dat (o_wb_dat),
    .o_wb_ack (o_wb_ack),
    .i_src    (i_src),
    .o_irq    (o_irq),
    .i_ack    (i_ack)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_claim_id();
    for (int i = 0; i < NUM_SRC; i++)
      if (m_pend[i] && m_en[i]) return 32'(i + 1);
    return 32'd0;
  endfunction

  function automatic logic model_irq();
    return !m_insvc && ((m_pend & m_en) != 8'h00);
  endfunction

  task automatic model_settle();
    m_pend = m_pend | (m_type & m_level_hi);
  endtask

  task automatic bus(input logic w, input logic [2:0] idx, input logic [31:0] d,
                     output logic [31:0] rd);
    int waited;
    waited = 0;
    @(negedge i_clk);
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we  = w;
    i_wb_adr = ($urandom & ~32'h1C) | (32'(idx) << 2);
    i_wb_dat = d;
    i_wb_sel = 4'($urandom_range(0, 15));
    @(negedge i_clk);
    while (!o_wb_ack && waited < 4) begin
      @(negedge i_clk);
      waited++;
    end
    check_val("wb_ack", 32'(o_wb_ack), 32'd1);
    rd = o_wb_dat;
    @(negedge i_clk);
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] idx, input string tag);
    logic [31:0] rd;
    logic [31:0] exp;
    case (idx)
      3'd0: exp = 32'(m_pend);
      3'd1: exp = 32'(m_en);
      3'd2: exp = model_claim_id();
`ifdef PLIC_LEVEL_EN
      3'd4: exp = 32'(m_type);
`endif
      default: exp = 32'd0;
    endcase
    bus(1'b0, idx, 32'd0, rd);
    if (idx == 3'd2 && exp != 32'd0) m_pend[exp - 1] = 1'b0;
    model_settle();
    check_val(tag, rd, exp);
  endtask

  task automatic reg_write(input logic [2:0] idx, input logic [31:0] d);
    logic [31:0] rd;
    bus(1'b1, idx, d, rd);
    case (idx)
      3'd0: m_pend = m_pend & ~d[7:0];
      3'd1: m_en = d[7:0];
      3'd3: m_insvc = 1'b0;
`ifdef PLIC_LEVEL_EN
      3'd4: m_type = d[7:0];
`endif
      default: ;
    endcase
    model_settle();
  endtask

  task automatic pulse_src(input logic [7:0] mask);
    @(negedge i_clk);
    i_src = i_src | mask;
    @(negedge i_clk);
    i_src = i_src & ~mask;
    repeat (5) @(negedge i_clk);
    m_pend = m_pend | mask;
    model_settle();
  endtask

  task automatic check_irq(input string tag);
    repeat (3) @(negedge i_clk);
    check_val(tag, 32'(o_irq), 32'(model_irq()));
  endtask

  task automatic ack_core();
    logic was;
    was = model_irq();
    @(negedge i_clk);
    i_ack = 1'b1;
    @(negedge i_clk);
    i_ack = 1'b0;
    if (was) m_insvc = 1'b1;
  endtask

  initial begin
    int n_ack;
    int op;
    logic [2:0] ridx;

    // Reset
    repeat (3) @(negedge i_clk);
    check_val("rst_irq", 32'(o_irq), 32'd0);
    check_val("rst_ack", 32'(o_wb_ack), 32'd0);
    check_val("rst_dat", o_wb_dat, 32'd0);
    i_rstn = 1'b1;
    reg_read(3'd0, "rst_pending");
    reg_read(3'd1, "rst_enable");
    reg_read(3'd2, "rst_claim");

    // Disabled source still goes pending but never raises irq
    pulse_src(8'h08);
    reg_read(3'd0, "dis_pending");
    check_irq("dis_irq");
    reg_write(3'd0, 32'h08);
    reg_read(3'd0, "w1c_pending");

    // Basic flow with exact assertion latency
    reg_write(3'd1, 32'hFF);
    @(negedge i_clk);
    i_src[2] = 1'b1;
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    check_val("basic_irq_lat", 32'(o_irq), 32'd1);
    i_src[2] = 1'b0;
    m_pend = m_pend | 8'h04;
    ack_core();
    check_irq("basic_irq_taken");
    reg_read(3'd2, "basic_claim");
    reg_read(3'd0, "basic_pending");
    reg_write(3'd3, 32'h0);
    check_irq("basic_after_complete");

    // Priority and re-assert after complete
    pulse_src(8'h22);
    check_irq("prio_irq");
    ack_core();
    reg_read(3'd2, "prio_claim_a");
    reg_write(3'd3, 32'h0);
    check_irq("prio_reassert");
    reg_read(3'd2, "prio_claim_b");
    reg_read(3'd2, "prio_claim_none");
    check_irq("prio_idle");

    // Withdraw while asserted
    reg_write(3'd1, 32'h01);
    pulse_src(8'h01);
    check_irq("wd_irq");
    reg_write(3'd1, 32'h00);
    check_irq("wd_drop");
    reg_read(3'd0, "wd_pending");
    reg_write(3'd0, 32'hFF);

    // Edge landing on the same cycle as its W1C: set wins
    pulse_src(8'h10);
    @(negedge i_clk);
    i_src[4] = 1'b1;
    reg_write(3'd0, 32'h10);
    m_pend = m_pend | 8'h10;
    i_src[4] = 1'b0;
    reg_read(3'd0, "collide_pending");
    reg_write(3'd0, 32'hFF);

    // Held strobe completes once every two cycles
    @(negedge i_clk);
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we  = 1'b0;
    i_wb_adr = 32'h4;
    n_ack = 0;
    repeat (6) begin
      @(negedge i_clk);
      if (o_wb_ack) n_ack++;
    end
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    check_val("held_stb_acks", 32'(n_ack), 32'd3);
    @(negedge i_clk);
    check_val("idle_dat", o_wb_dat, 32'd0);

`ifdef PLIC_LEVEL_EN
    reg_write(3'd4, 32'h01);
    reg_write(3'd1, 32'h01);
    @(negedge i_clk);
    i_src[0] = 1'b1;
    m_level_hi = 8'h01;
    repeat (5) @(negedge i_clk);
    m_pend = m_pend | 8'h01;
    reg_read(3'd4, "lvl_type");
    reg_read(3'd2, "lvl_claim_1");
    reg_read(3'd2, "lvl_claim_2");
    reg_read(3'd2, "lvl_claim_3");
    i_src[0] = 1'b0;
    m_level_hi = 8'h00;
    repeat (4) @(negedge i_clk);
    reg_write(3'd0, 32'h01);
    reg_read(3'd2, "lvl_claim_none");
    reg_write(3'd4, 32'h00);
`else
    reg_write(3'd4, 32'hFF);
    reg_read(3'd4, "type_reads0");
`endif
    reg_write(3'd0, 32'hFF);
    reg_write(3'd3, 32'h0);
    check_irq("pre_rnd_irq");

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 7));
      case (op)
        0: pulse_src(8'($urandom_range(1, 255)));
        1: reg_write(3'd1, $urandom);
        2: reg_write(3'd0, $urandom);
        3: reg_read(3'd2, "rnd_claim");
        4: reg_read(3'($urandom_range(0, 1)), "rnd_read");
        5: reg_write(3'd3, $urandom);
        6: ack_core();
        default: begin
          ridx = 3'($urandom_range(5, 7));
          reg_write(ridx, $urandom);
          reg_read(ridx, "rnd_unmapped");
        end
      endcase
      check_irq("rnd_irq");
    end

    // Reset in the middle of an acknowledged transfer
    reg_write(3'd1, 32'hAA);
    @(negedge i_clk);
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we  = 1'b0;
    i_wb_adr = 32'h4;
    @(negedge i_clk);
    check_val("mid_ack_seen", 32'(o_wb_ack), 32'd1);
    i_rstn   = 1'b0;
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    @(negedge i_clk);
    check_val("mid_rst_ack", 32'(o_wb_ack), 32'd0);
    check_val("mid_rst_irq", 32'(o_irq), 32'd0);
    i_rstn = 1'b1;
    m_pend  = '0;
    m_en    = '0;
    m_type  = '0;
    m_insvc = 1'b0;
    reg_read(3'd1, "mid_rst_enable");
    reg_read(3'd0, "mid_rst_pending");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
